ram_loader: RTL and testbench
=============================

# ram_loader

Program loader on the write side of the CPU's 256×16 RAM. It accepts a framed byte stream from a host link over a valid/ready handshake, assembles the bytes into 16-bit words and writes them into consecutive RAM addresses. It holds the CPU in reset until a frame has loaded cleanly. It sits beside `top`, muxed onto the RAM's address, data and write-enable inputs ahead of the MBR/MAR path while `cpu_rst` is high.

## Interface
Parameters:
- `BASE_ADDR`, 8'h00, first RAM address written by a frame.
- `SYNC_BYTE`, 8'hA5, frame start marker.

Ports:
- `clk`, input, 1, single system clock; all logic on the rising edge.
- `rst`, input, 1, reset: synchronous, active-high.
- `byte_in`, input, 8, host byte.
- `byte_valid`, input, 1, `byte_in` holds a byte.
- `byte_ready`, output, 1, loader accepts the byte this cycle. A transfer occurs when valid and ready are both high.
- `mem_addr`, output, 8, RAM write address.
- `mem_data`, output, 16, RAM write data.
- `mem_we`, output, 1, one-cycle RAM write strobe.
- `cpu_rst`, output, 1, reset to the CPU core; high while not loaded.
- `load_done`, output, 1, last frame loaded successfully (level).
- `load_err`, output, 1, last frame failed its checksum (level).

## Operation
Frame format: `SYNC_BYTE`, then count N (number of words; 0 means 256), then N words sent high byte first, then a checksum byte. The checksum byte is present only when `LOADER_CHECKSUM_EN` is defined.

FSM states:
- **IDLE**: `byte_ready`=1. Bytes other than `SYNC_BYTE` are discarded. On `SYNC_BYTE`, go to CNT and clear the checksum.
- **CNT**: latch N into a 9-bit word counter (0→256). Set the address pointer to `BASE_ADDR`. Go to HI.
- **HI**: latch `data[15:8]`. Go to LO.
- **LO**: latch `data[7:0]`. Go to WR.
- **WR**: `byte_ready`=0. Assert `mem_we` with `mem_addr`=pointer and `mem_data`=assembled word. Increment the pointer modulo 256 (wraps FF→00). Decrement the counter. If the counter becomes 0, go to CHK (with checksum) or DONE (without); otherwise go to HI.
- **CHK**: compare the received byte with the running checksum. Equal → DONE; otherwise → ERR.
- **DONE**: `cpu_rst`=0, `load_done`=1, `byte_ready`=1. A `SYNC_BYTE` re-enters CNT: `cpu_rst` returns to 1 and `load_done` clears in the same edge. Other bytes are discarded.
- **ERR**: `cpu_rst`=1, `load_err`=1, `byte_ready`=1. A `SYNC_BYTE` re-enters CNT and clears `load_err`.

Checksum:
- XOR of every data byte (HI and LO bytes only). The count byte is excluded.

Other rules:
- A sync-valued byte arriving inside a frame is treated as data. There is no resync mid-frame.
- The host may drop `byte_valid` at any point. The FSM simply waits, with no timeout.

## Timing
Reset values:
- state=IDLE, `byte_ready`=1, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_data`=0, `cpu_rst`=1, `load_done`=0, `load_err`=0, checksum=0.
- Reset mid-frame abandons the frame immediately.
- RAM words already written are left as they are.

Latency and throughput:
- `mem_we` rises on the cycle after the LO byte handshake and is high for exactly 1 cycle.
- `byte_ready` is low only in WR. Peak rate is therefore 2 bytes per 3 cycles.
- `cpu_rst` falls on the edge after the final byte handshake: the checksum byte with the macro, or the WR cycle of the last word without it.
- `byte_ready` is registered. It never depends combinationally on `byte_valid`.

## Configuration
`LOADER_CHECKSUM_EN`:
- **Defined**: the frame carries the trailing checksum byte. The CHK state and the checksum register exist. A mismatch goes to ERR.
- **Undefined**: there is no checksum byte. WR goes straight to DONE after the last word. `load_err` is tied 0 and the ERR state is unreachable.

## Structure
- Shared package `cpu_pkg`: the loader state enum, the `SYNC_BYTE` default, and the RAM `ADDR_W`=8 / `DATA_W`=16 constants used by MAR/MBR/RAM.
- One sub-module, `word_assembler`: takes the HI and LO bytes, produces the 16-bit word, and keeps the XOR accumulator.
- The FSM, address pointer and counter stay in `ram_loader`.

## Test plan
- Frame A5, 02, 12 34, AB CD, chk=12^34^AB^CD=40 → writes 1234@00, ABCD@01; `mem_we` pulses twice; `cpu_rst` falls; `load_done`=1.
- Same frame with chk=41 → `load_err`=1, `cpu_rst` stays 1. A new valid frame then clears `load_err` and lands in DONE.
- `BASE_ADDR`=FE, count 03 → writes land at FE, FF, 00 (wrap).
- Count 00 → exactly 256 writes covering 00..FF, then DONE.
- Leading junk 00, 5A before A5 → ignored, no writes. `rst` pulsed after the HI byte of word 1 → no write, state IDLE, `cpu_rst`=1.
- `byte_valid` toggled every other cycle mid-frame → identical RAM contents. `byte_ready` is low only during the WR cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: RAM geometry, loader sync byte and loader FSM state encodings.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  localparam logic [7:0] SyncByteDef = 8'hA5;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCnt  = 3'd1;
  localparam logic [2:0] StHi   = 3'd2;
  localparam logic [2:0] StLo   = 3'd3;
  localparam logic [2:0] StWr   = 3'd4;
  localparam logic [2:0] StChk  = 3'd5;
  localparam logic [2:0] StDone = 3'd6;
  localparam logic [2:0] StErr  = 3'd7;

endpackage

// File: rtl/word_assembler.sv
// Builds a 16-bit word from high/low bytes; keeps the frame XOR checksum when
// LOADER_CHECKSUM_EN is defined (otherwise csum_o is tied 0).
module word_assembler
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic [7:0]        csum_o
);

  logic [DATA_W-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (hi_we_i) word_d[15:8] = byte_i;
    if (lo_we_i) word_d[7:0]  = byte_i;
  end

  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign word_o = word_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clear_i)                 csum_d = 8'h00;
    else if (hi_we_i || lo_we_i) csum_d = csum_q ^ byte_i;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= 8'h00;
    else     csum_q <= csum_d;
  end

  assign csum_o = csum_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign csum_o       = 8'h00;
`endif

endmodule

// File: rtl/ram_loader.sv
// Framed byte-stream program loader for the 256x16 CPU RAM; holds the CPU in reset
// until a frame loads. Trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module ram_loader
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter logic [7:0]        SYNC_BYTE = SyncByteDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  logic [2:0]        state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clear, hi_we, lo_we, xfer, is_sync;
  logic [7:0]        csum;

  assign xfer    = byte_valid && byte_ready;
  assign is_sync = (byte_in == SYNC_BYTE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    clear   = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer && is_sync) begin
          state_d = StCnt;
          clear   = 1'b1;
        end
      end
      StCnt: begin
        if (xfer) begin
          // A count of zero encodes a full 256-word frame.
          cnt_d   = {byte_in == 8'h00, byte_in};
          ptr_d   = BASE_ADDR;
          state_d = StHi;
        end
      end
      StHi: begin
        if (xfer) begin
          hi_we   = 1'b1;
          state_d = StLo;
        end
      end
      StLo: begin
        if (xfer) begin
          lo_we   = 1'b1;
          state_d = StWr;
        end
      end
      StWr: begin
        ptr_d = ptr_q + 8'd1;
        cnt_d = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StHi;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) state_d = (byte_in == csum) ? StDone : StErr;
      end
      StErr: begin
        if (xfer && is_sync) begin
          state_d = StCnt;
          clear   = 1'b1;
        end
      end
`endif
      StDone: begin
        if (xfer && is_sync) begin
          state_d = StCnt;
          clear   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 9'd0;
      ptr_q   <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  word_assembler u_word_assembler (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .byte_i  (byte_in),
    .word_o  (mem_data),
    .csum_o  (csum)
  );

  // All outputs decode the registered state only.
  assign byte_ready = (state_q != StWr);
  assign mem_we     = (state_q == StWr);
  assign mem_addr   = ptr_q;
  assign cpu_rst    = (state_q != StDone);
  assign load_done  = (state_q == StDone);

`ifdef LOADER_CHECKSUM_EN
  assign load_err = (state_q == StErr);
`else
  logic unused_csum;
  assign unused_csum = ^csum;
  assign load_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader; follows LOADER_CHECKSUM_EN to add trailing checksum bytes.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        ready0, we0, cpu_rst0, done0, err0;
  logic [7:0]  addr0;
  logic [15:0] data0;
  logic        ready1, we1, cpu_rst1, done1, err1;
  logic [7:0]  addr1;
  logic [15:0] data1;

  int vectors = 0;
  int miscompares = 0;
  int ready_viol = 0;
  bit started = 1'b0;

  logic [23:0] log0[$];
  logic [23:0] log1[$];
  logic [7:0]  tx[$];

  always #5 clk = ~clk;

  ram_loader #(.BASE_ADDR(8'h00), .SYNC_BYTE(8'hA5)) u0 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready0),
    .mem_addr(addr0), .mem_data(data0), .mem_we(we0), .cpu_rst(cpu_rst0),
    .load_done(done0), .load_err(err0)
  );

  ram_loader #(.BASE_ADDR(8'hFE), .SYNC_BYTE(8'hA5)) u1 (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready1),
    .mem_addr(addr1), .mem_data(data1), .mem_we(we1), .cpu_rst(cpu_rst1),
    .load_done(done1), .load_err(err1)
  );

  always @(posedge clk) begin
    if (we0 === 1'b1) log0.push_back({addr0, data0});
    if (we1 === 1'b1) log1.push_back({addr1, data1});
  end

  // byte_ready must be the exact complement of the write strobe (low only in WR).
  always @(negedge clk) begin
    if (started && !rst && (ready0 === we0)) ready_viol++;
  end

  task automatic clear_log();
    log0.delete();
    log1.delete();
  endtask

  task automatic pulse_rst();
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge just after the last handshake.
  task automatic send_tx(input bit gap);
    for (int i = 0; i < tx.size(); i++) begin
      int guard = 0;
      if (gap) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
      byte_in = tx[i];
      byte_valid = 1'b1;
      while (!ready0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 10) begin
        vectors++; miscompares++;
        $display("FAIL ready_timeout byte %0d: byte_ready stuck %b, required 1", i, ready0);
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    tx.delete();
  endtask

  task automatic push_basic(input logic [7:0] chk);
    tx = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(chk);
`else
    if (chk == 8'h00) tx.push_back(8'h00); // never taken for the values used
    if (chk == 8'h00) void'(tx.pop_back());
`endif
  endtask

  task automatic test_reset();
    vectors++; if (ready0 !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", ready0); end
    vectors++; if (we0 !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b want 0", we0); end
    vectors++; if (addr0 !== 8'h00) begin miscompares++; $display("FAIL rst_addr got %h want 00", addr0); end
    vectors++; if (addr1 !== 8'hFE) begin miscompares++; $display("FAIL rst_addr_fe got %h want fe", addr1); end
    vectors++; if (data0 !== 16'h0000) begin miscompares++; $display("FAIL rst_data got %h want 0000", data0); end
    vectors++; if (cpu_rst0 !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_rst got %b want 1", cpu_rst0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done0); end
    vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err0); end
  endtask

  task automatic check_basic_log(input string tag);
    vectors++;
    if (log0.size() != 2 || log0[0] !== 24'h00_1234 || log0[1] !== 24'h01_ABCD) begin
      miscompares++;
      $display("FAIL %s_writes got %0d writes [0]=%h [1]=%h want 001234 01abcd", tag,
               log0.size(), (log0.size() > 0) ? log0[0] : 24'hx, (log0.size() > 1) ? log0[1] : 24'hx);
    end
  endtask

  task automatic test_basic();
    logic exp_rst_now;
    clear_log();
    push_basic(8'h40);
    send_tx(1'b0);
`ifdef LOADER_CHECKSUM_EN
    exp_rst_now = 1'b0;
`else
    exp_rst_now = 1'b1;
`endif
    vectors++;
    if (cpu_rst0 !== exp_rst_now) begin
      miscompares++; $display("FAIL basic_rst_timing got %b want %b", cpu_rst0, exp_rst_now);
    end
    @(negedge clk);
    check_basic_log("basic");
    vectors++;
    if (log1.size() != 2 || log1[0] !== 24'hFE_1234 || log1[1] !== 24'hFF_ABCD) begin
      miscompares++; $display("FAIL basic_base_fe got %0d writes, want FE,FF", log1.size());
    end
    vectors++; if (cpu_rst0 !== 1'b0) begin miscompares++; $display("FAIL basic_cpu_rst got %b want 0", cpu_rst0); end
    vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL basic_done got %b want 1", done0); end
    vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", err0); end
  endtask

  task automatic test_checksum_err();
`ifdef LOADER_CHECKSUM_EN
    push_basic(8'h41);
    send_tx(1'b0);
    @(negedge clk);
    vectors++; if (err0 !== 1'b1) begin miscompares++; $display("FAIL chk_err got %b want 1", err0); end
    vectors++; if (cpu_rst0 !== 1'b1) begin miscompares++; $display("FAIL chk_cpu_rst got %b want 1", cpu_rst0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL chk_done got %b want 0", done0); end
    push_basic(8'h40);
    send_tx(1'b0);
    vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL chk_err_clear got %b want 0", err0); end
    vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL chk_recover got %b want 1", done0); end
`endif
  endtask

  task automatic test_wrap();
    clear_log();
    tx = '{8'hA5, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'h00);
`endif
    send_tx(1'b0);
    @(negedge clk);
    vectors++;
    if (log1.size() != 3 || log1[0] !== 24'hFE_1111 || log1[1] !== 24'hFF_2222 ||
        log1[2] !== 24'h00_3333) begin
      miscompares++; $display("FAIL wrap_addr got %0d writes first=%h last=%h want FE,FF,00",
                              log1.size(), (log1.size() > 0) ? log1[0] : 24'hx,
                              (log1.size() > 2) ? log1[2] : 24'hx);
    end
    vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %b want 1", done1); end
  endtask

  task automatic test_count_zero();
    int bad = 0;
    clear_log();
    tx = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b = 8'(i);
      tx.push_back(b);
      tx.push_back(~b);
    end
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'h00); // each word XORs to FF; 256 of them cancel
`endif
    send_tx(1'b0);
    @(negedge clk);
    for (int i = 0; i < 256 && i < log0.size(); i++) begin
      logic [7:0] b = 8'(i);
      if (log0[i] !== {b, b, ~b}) bad++;
    end
    vectors++;
    if (log0.size() != 256 || bad != 0) begin
      miscompares++; $display("FAIL count0_writes got %0d writes %0d wrong, want 256 0", log0.size(), bad);
    end
    vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL count0_done got %b want 1", done0); end
  endtask

  task automatic test_junk_and_reset();
    pulse_rst();
    clear_log();
    tx = '{8'h00, 8'h5A};
    send_tx(1'b0);
    @(negedge clk);
    vectors++; if (log0.size() != 0) begin miscompares++; $display("FAIL junk_writes got %0d want 0", log0.size()); end
    vectors++; if (cpu_rst0 !== 1'b1) begin miscompares++; $display("FAIL junk_cpu_rst got %b want 1", cpu_rst0); end
    tx = '{8'hA5, 8'h02, 8'h12};
    send_tx(1'b0);
    pulse_rst();
    repeat (3) @(negedge clk);
    vectors++; if (log0.size() != 0) begin miscompares++; $display("FAIL midrst_writes got %0d want 0", log0.size()); end
    vectors++;
    if (cpu_rst0 !== 1'b1 || done0 !== 1'b0 || ready0 !== 1'b1 || addr0 !== 8'h00) begin
      miscompares++; $display("FAIL midrst_idle got rst=%b done=%b ready=%b addr=%h want 1 0 1 00",
                              cpu_rst0, done0, ready0, addr0);
    end
    push_basic(8'h40);
    send_tx(1'b0);
    @(negedge clk);
    check_basic_log("after_rst");
  endtask

  task automatic test_back_to_back();
    clear_log();
    push_basic(8'h40);
    send_tx(1'b1);
    @(negedge clk);
    check_basic_log("gap");
    vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL gap_done got %b want 1", done0); end
    vectors++;
    if (ready_viol != 0) begin
      miscompares++; $display("FAIL ready_vs_wr got %0d violations want 0", ready_viol);
    end
  endtask

  initial begin
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;
    test_reset();
    test_basic();
    test_checksum_err();
    test_wrap();
    test_count_zero();
    test_junk_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
